ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu_pkg.sv | 23 ++
 rtl/ifu_fifo.sv | 65 ++++++
 rtl/ifu.sv | 112 +++++++++++
 tb/tb_ifu.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the fetch FSM state encoding, the default reset fetch address,
// the buffer geometry and a word-alignment helper.
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } ifu_state_t;

  localparam logic [31:0] IFU_RESET_PC  = 32'h0000_3000;
  localparam int          IFU_BUF_DEPTH = 2;
  // Buffer entry layout: {pc[31:0], instruction[31:0]}
  localparam int          IFU_ENTRY_W   = 64;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small FIFO holding fetched {pc, instruction} entries for decode.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: pushes are dropped when full unless a pop frees a slot; flush wins over push/pop.
// Ports: clk/rst_n; push/wdata write side; pop/rdata read side (head); flush empties; count = occupancy.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = IFU_BUF_DEPTH,
  parameter int W     = IFU_ENTRY_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);

  // Head comes straight from storage so decode sees it without an extra stage.
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding word fetch at a time, results queued for decode.
// Latency: grant -> rvalid -> inst_valid on the following cycle; one fetch per two cycles at best.
// Backpressure: stops requesting while the 2-entry buffer is full; redirect flushes buffer and in-flight data.
// Ports: clk, rst_n; npc_i/redirect from next-PC logic; imem_req/imem_addr/imem_gnt request side;
// imem_rvalid/imem_rdata response side; inst_valid/inst_ready/inst/inst_pc towards decode.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IFU_RESET_PC,
  parameter int          BUF_DEPTH = IFU_BUF_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc_i,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  ifu_state_t  state;
  ifu_state_t  state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic        push;
  logic        pop;
  logic [CW-1:0] count;
  logic [IFU_ENTRY_W-1:0] head;

  // Requests only go out when a returned word is guaranteed a buffer slot.
  assign imem_req   = (state == ST_REQ) && (count != FULL);
  assign imem_addr  = pc;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst       = head[31:0];
  assign inst_pc    = head[63:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc    <= word_align(RESET_PC);
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        state_nxt = ST_REQ;
      end
      ST_REQ: begin
        // A grant alongside a redirect fetches a stale address: its data must be dropped.
        if (imem_req && imem_gnt) begin
          state_nxt = redirect ? ST_FLUSH : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_nxt = ST_REQ;
          if (!redirect) begin
            push   = 1'b1;
            pc_nxt = pc + 32'd4;
          end
        end else if (redirect) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // The stale response always ends the flush, even if another redirect
        // arrives with it; nothing else is in flight to wait for.
        if (imem_rvalid) begin
          state_nxt = ST_REQ;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (redirect) begin
      pc_nxt = word_align(npc_i);
    end
  end

  ifu_fifo #(
    .DEPTH (BUF_DEPTH),
    .W     (IFU_ENTRY_W)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({pc, imem_rdata}),
    .rdata (head),
    .count (count)
  );

endmodule

// File: tb/tb_ifu.sv
// Bench for the fetch unit: random memory/decode/redirect stimulus against a
// queue-based model of fetch behaviour, plus directed scenarios with literal
// expected addresses.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] npc_i = '0;
  logic        redirect = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  ifu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .npc_i       (npc_i),
    .redirect    (redirect),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Fetch is described as: a next address, a list of buffered {pc,word},
  // whether a request is in flight and whether its answer is already stale.
  logic [31:0] m_pc = '0;
  logic [63:0] m_buf[$];
  bit          m_out = 0;
  bit          m_drop = 0;
  bit          m_live = 0;

  initial begin
    bit can_req;
    bit resp;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pc = 32'h0000_3000;
        m_buf.delete();
        m_out = 0;
        m_drop = 0;
        m_live = 0;
      end else begin
        can_req = m_live && !m_out && (m_buf.size() < 2);
        resp = m_out && imem_rvalid;
        if (redirect) begin
          m_buf.delete();
        end else begin
          if (m_buf.size() > 0 && inst_ready) void'(m_buf.pop_front());
          if (resp && !m_drop) begin
            m_buf.push_back({m_pc, imem_rdata});
            m_pc = m_pc + 32'd4;
          end
        end
        if (resp) begin
          m_out = 0;
          m_drop = 0;
        end else if (m_out && redirect) begin
          m_drop = 1;
        end
        if (can_req && imem_gnt) begin
          m_out = 1;
          m_drop = redirect;
        end
        if (redirect) m_pc = npc_i & 32'hFFFF_FFFC;
        m_live = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    bit exp_req;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
      end else begin
        exp_req = m_live && !m_out && (m_buf.size() < 2);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", imem_addr, m_pc);
        check("inst_valid", 32'(inst_valid), 32'(m_buf.size() != 0));
        if (m_buf.size() != 0) begin
          check("inst", inst, m_buf[0][31:0]);
          check("inst_pc", inst_pc, m_buf[0][63:32]);
        end
      end
    end
  end

  // ---------------- stimulus / memory ----------------
  int          gnt_pct = 100;
  int          rdy_pct = 0;
  int          dly_min = 1;
  int          dly_max = 1;
  int          redir_pct = 0;
  int          redir_arm = 0;   // 1: redirect next cycle, 2: redirect with next rvalid (+pop)
  logic [31:0] redir_npc = '0;
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  bit          granted = 0;
  logic [31:0] gaddr[$];
  logic [31:0] popped[$];

  task automatic cycle();
    @(posedge clk);
    #1;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    npc_i       = $urandom;
    if (!rst_n) begin
      mem_pend = 0;
    end else if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        imem_rvalid = 1'b1;
        mem_pend = 0;
      end
    end
    inst_ready = ($urandom_range(99) < rdy_pct);
    if (redir_arm == 1 || (redir_arm == 2 && imem_rvalid)) begin
      redirect = 1'b1;
      npc_i = redir_npc;
      if (redir_arm == 2) inst_ready = 1'b1;
      redir_arm = 0;
    end else if ($urandom_range(99) < redir_pct) begin
      redirect = 1'b1;
      if ($urandom_range(3) == 0) npc_i = 32'hFFFF_FFF0 | (npc_i & 32'h0000_000F);
    end
    imem_gnt = ($urandom_range(99) < gnt_pct);
    granted = rst_n && imem_req && imem_gnt;
    if (granted) begin
      gaddr.push_back(imem_addr);
      mem_pend = 1;
      mem_cnt = $urandom_range(dly_max, dly_min);
    end
    if (rst_n && inst_valid && inst_ready && !redirect) popped.push_back(inst_pc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redir_arm = 0;
    repeat (3) cycle();
    rst_n = 1'b1;
    gaddr.delete();
    popped.delete();
  endtask

  task automatic wait_grants(input string name, input int n);
    int k = 0;
    while (gaddr.size() < n && k < 100) begin
      cycle();
      k++;
    end
    check(name, 32'(gaddr.size() >= n), 32'd1);
  endtask

  task automatic check_q(input string name, input bit use_pop, input int idx, input logic [31:0] exp);
    int sz;
    sz = use_pop ? popped.size() : gaddr.size();
    if (idx >= sz) begin
      checks++;
      failures++;
      $display("FAIL %s: entry %0d missing (have %0d), expected %h", name, idx, sz, exp);
    end else begin
      check(name, use_pop ? popped[idx] : gaddr[idx], exp);
    end
  endtask

  initial begin
    int n0;
    int k;

    // Startup sequence with an always-granting memory and decode stalled.
    gnt_pct = 100; rdy_pct = 0; dly_min = 1; dly_max = 1; redir_pct = 0;
    do_reset();
    repeat (12) cycle();
    check("a_grant_count", 32'(gaddr.size()), 32'd2);
    check_q("a_addr0", 0, 0, 32'h0000_3000);
    check_q("a_addr1", 0, 1, 32'h0000_3004);
    check("a_req_stalled", 32'(imem_req), 32'd0);
    check("a_head_pc", inst_pc, 32'h0000_3000);
    rdy_pct = 100;
    repeat (12) cycle();
    check_q("a_addr2", 0, 2, 32'h0000_3008);
    check_q("a_pop0", 1, 0, 32'h0000_3000);
    check_q("a_pop1", 1, 1, 32'h0000_3004);
    check_q("a_pop2", 1, 2, 32'h0000_3008);

    // Redirect while a fetch is outstanding: its data is dropped.
    rdy_pct = 0; dly_min = 2; dly_max = 2;
    do_reset();
    wait_grants("b_two_grants", 2);
    redir_arm = 1; redir_npc = 32'h0000_4001;
    n0 = gaddr.size();
    cycle();
    cycle();
    check("b_buf_empty", 32'(inst_valid), 32'd0);
    check("b_no_req_flush", 32'(imem_req), 32'd0);
    wait_grants("b_regrant", n0 + 1);
    check_q("b_addr_after", 0, n0, 32'h0000_4000);
    repeat (4) cycle();
    check("b_head_pc", inst_pc, 32'h0000_4000);

    // Redirect together with rvalid and a pop.
    rdy_pct = 0; dly_min = 2; dly_max = 2;
    do_reset();
    wait_grants("c_two_grants", 2);
    redir_arm = 2; redir_npc = 32'h0000_5008;
    k = 0;
    while (redir_arm != 0 && k < 20) begin
      cycle();
      k++;
    end
    check("c_redirect_fired", 32'(redir_arm), 32'd0);
    cycle();
    check("c_buf_empty", 32'(inst_valid), 32'd0);
    check("c_req", 32'(imem_req), 32'd1);
    check("c_addr", imem_addr, 32'h0000_5008);

    // Address wrap at the top of memory.
    rdy_pct = 100; dly_min = 1; dly_max = 1;
    do_reset();
    redir_arm = 2; redir_npc = 32'hFFFF_FFFC;
    k = 0;
    while (redir_arm != 0 && k < 20) begin
      cycle();
      k++;
    end
    n0 = gaddr.size();
    wait_grants("d_grants", n0 + 2);
    check_q("d_addr_top", 0, n0, 32'hFFFF_FFFC);
    check_q("d_addr_wrap", 0, n0 + 1, 32'h0000_0000);

    // Reset while waiting on memory.
    rdy_pct = 0; dly_min = 3; dly_max = 3;
    do_reset();
    wait_grants("e_two_grants", 2);
    cycle();
    check("e_pre_valid", 32'(inst_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("e_req_rst", 32'(imem_req), 32'd0);
    check("e_valid_rst", 32'(inst_valid), 32'd0);
    check("e_inst_rst", inst, 32'd0);
    check("e_pc_rst", inst_pc, 32'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    gaddr.delete();
    wait_grants("e_regrant", 1);
    check_q("e_first_addr", 0, 0, 32'h0000_3000);

    // Random traffic against the model.
    gnt_pct = 70; rdy_pct = 60; dly_min = 1; dly_max = 3; redir_pct = 5;
    do_reset();
    repeat (3000) cycle();
    rdy_pct = 20; redir_pct = 10; gnt_pct = 90;
    repeat (1500) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
